ramp_group_packer: RTL and testbench

- Downstream consumer of the 3-bit ramp counter that emits 1 | 1,2 | 1,2,3 | … | 1..7 and then repeats.
- Splits the incoming sample stream into groups; each group starts at a sample equal to 1.
- For each closed group it produces a record {length, sum, error}.
- Records are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake.

---
 rtl/ramp_group_packer_if.sv | 28 ++
 rtl/ramp_group_packer.sv | 197 +++++++++++++++++++
 tb/tb_ramp_group_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ramp_group_packer_if.sv
// Handshake bundle between the ramp sample source, the group packer and the record consumer.
// The packer sits on the slave side; the bench or upstream logic uses the master side.
interface ramp_group_packer_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

    logic             in_valid;
    logic [2:0]       in_data;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_len;
    logic [5:0]       out_sum;
    logic             out_err;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport slave (
        input  in_valid, in_data, in_flush, out_ready,
        output out_valid, out_len, out_sum, out_err, fifo_count, overflow
    );

    modport master (
        output in_valid, in_data, in_flush, out_ready,
        input  out_valid, out_len, out_sum, out_err, fifo_count, overflow
    );
endinterface

// File: rtl/ramp_group_packer.sv
// Groups a ramp sample stream into {length, sum, error} records, one per group starting at 1,
// and buffers them in a small first-word-fall-through FIFO with registered head outputs.
module ramp_group_packer #(
    parameter int DEPTH   = 4,
    parameter int MAX_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    ramp_group_packer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 11;
    localparam logic [3:0]       MAX_LEN_C = 4'(MAX_LEN);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    state_t     state_r, state_nx_s;
    logic [2:0] prev_r, prev_nx_s;
    logic [3:0] len_r, len_nx_s;
    logic [5:0] sum_r, sum_nx_s;
    logic       err_r, err_nx_s;

    logic             push_s;
    logic [REC_W-1:0] push_rec_s;
    logic [3:0]       grow_len_s;
    logic [5:0]       grow_sum_s;
    logic             grow_err_s;

    logic [REC_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_nx_s, wr_ptr_nx_s;
    logic [CNT_W-1:0] count_r, count_nx_s, kept_s;
    logic             valid_r;
    logic [REC_W-1:0] head_r, head_nx_s;
    logic             ovf_r;
    logic             pop_s, full_s, accept_s, drop_s;

    // Extending an open group; any step other than prev+1 (including 7 -> 0) flags an error
    always_comb begin
        grow_len_s = len_r + 4'd1;
        grow_sum_s = sum_r + {3'b000, bus.in_data};
        grow_err_s = err_r | (({1'b0, prev_r} + 4'd1) != {1'b0, bus.in_data});
    end

    // Collector state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            prev_r  <= 3'd0;
            len_r   <= 4'd0;
            sum_r   <= 6'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            prev_r  <= prev_nx_s;
            len_r   <= len_nx_s;
            sum_r   <= sum_nx_s;
            err_r   <= err_nx_s;
        end
    end

    // Collector next-state and record push decision
    always_comb begin
        state_nx_s = state_r;
        prev_nx_s  = prev_r;
        len_nx_s   = len_r;
        sum_nx_s   = sum_r;
        err_nx_s   = err_r;
        push_s     = 1'b0;
        push_rec_s = {len_r, sum_r, err_r};
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && (bus.in_data == 3'd1)) begin
                    state_nx_s = ST_OPEN;
                    prev_nx_s  = 3'd1;
                    len_nx_s   = 4'd1;
                    sum_nx_s   = 6'd1;
                    err_nx_s   = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (bus.in_valid) begin
                    if (bus.in_data == 3'd1) begin
                        push_s     = 1'b1;
                        state_nx_s = ST_OPEN;
                        prev_nx_s  = 3'd1;
                        len_nx_s   = 4'd1;
                        sum_nx_s   = 6'd1;
                        err_nx_s   = 1'b0;
                    end else if (grow_len_s == MAX_LEN_C) begin
                        push_s     = 1'b1;
                        push_rec_s = {grow_len_s, grow_sum_s, grow_err_s};
                        state_nx_s = ST_IDLE;
                        prev_nx_s  = 3'd0;
                        len_nx_s   = 4'd0;
                        sum_nx_s   = 6'd0;
                        err_nx_s   = 1'b0;
                    end else begin
                        prev_nx_s = bus.in_data;
                        len_nx_s  = grow_len_s;
                        sum_nx_s  = grow_sum_s;
                        err_nx_s  = grow_err_s;
                    end
                end else if (bus.in_flush) begin
                    push_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                    prev_nx_s  = 3'd0;
                    len_nx_s   = 4'd0;
                    sum_nx_s   = 6'd0;
                    err_nx_s   = 1'b0;
                end else begin
                    state_nx_s = ST_OPEN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // A full FIFO still takes a push when the head leaves on the same edge
    always_comb begin
        pop_s    = valid_r & bus.out_ready;
        full_s   = (count_r == DEPTH_C);
        accept_s = push_s & (~full_s | pop_s);
        drop_s   = push_s & full_s & ~pop_s;
    end

    // FIFO pointer and occupancy lookahead
    always_comb begin
        rd_ptr_nx_s = pop_s    ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        wr_ptr_nx_s = accept_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        kept_s      = pop_s ? (count_r - CNT_W'(1)) : count_r;
        case ({accept_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Head lookahead: when nothing survives the pop, the incoming record becomes the head
    always_comb begin
        head_nx_s = {REC_W{1'b0}};
        if (count_nx_s == {CNT_W{1'b0}}) begin
            head_nx_s = {REC_W{1'b0}};
        end else if (kept_s == {CNT_W{1'b0}}) begin
            head_nx_s = push_rec_s;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {REC_W{1'b0}};
            end
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= push_rec_s;
            end
        end
    end

    // FIFO control, registered head and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
            head_r   <= {REC_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
            valid_r  <= (count_nx_s != {CNT_W{1'b0}});
            head_r   <= head_nx_s;
            ovf_r    <= ovf_r | drop_s;
        end
    end

    assign bus.out_valid  = valid_r;
    assign bus.out_len    = head_r[10:7];
    assign bus.out_sum    = head_r[6:1];
    assign bus.out_err    = head_r[0];
    assign bus.fifo_count = count_r;
    assign bus.overflow   = ovf_r;
endmodule

// File: tb/tb_ramp_group_packer.sv
// Directed bench for ramp_group_packer: a cycle-level vector table plus record-level scenarios
// for forced close, backpressure/overflow and asynchronous reset.
module tb_ramp_group_packer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ramp_group_packer_if #(.DEPTH(4)) bus ();

    ramp_group_packer #(.DEPTH(4), .MAX_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       f;
        logic       rdy;
        logic       ev;
        logic [3:0] el;
        logic [5:0] es;
        logic       ee;
        logic [2:0] ec;
    } vec_t;

    logic [10:0] got[$];
    logic [10:0] exp_q[$];

    // Record every head accepted by the consumer
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got.push_back({bus.out_len, bus.out_sum, bus.out_err});
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_flush = 1'b0;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_data  = 3'd0;
    endtask

    task automatic flush();
        bus.in_valid = 1'b0;
        bus.in_flush = 1'b1;
        cyc();
        bus.in_flush = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
    endtask

    task automatic compare_records(input string name);
        check({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_rec%0d", name, i), int'(got[i]), int'(exp_q[i]));
        end
        got.delete();
        exp_q.delete();
    endtask

    function automatic logic [10:0] rec(input int l, input int s, input int e);
        return {4'(l), 6'(s), 1'(e)};
    endfunction

    vec_t vecs[10];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //            v     d     f     rdy   ev    len   sum   err   count
        vecs[0] = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 4'd1, 6'd1, 1'b0, 3'd1};
        vecs[2] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 3'd0};
        vecs[3] = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 4'd2, 6'd3, 1'b0, 3'd1};
        vecs[4] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 3'd0};
        vecs[5] = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 3'd0};
        vecs[6] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 4'd3, 6'd6, 1'b0, 3'd1};
        vecs[7] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 3'd0};
        vecs[8] = '{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 3'd0};
        vecs[9] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 3'd0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 3'd0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        check("reset_valid", int'(bus.out_valid), 0);
        check("reset_count", int'(bus.fifo_count), 0);
        check("reset_overflow", int'(bus.overflow), 0);
        check("reset_len", int'(bus.out_len), 0);
        check("reset_sum", int'(bus.out_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Cycle-level table: 1 | 1,2 | 1,2,3 + flush, then junk and a flush while idle
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = vecs[i].v;
            bus.in_data   = vecs[i].d;
            bus.in_flush  = vecs[i].f;
            bus.out_ready = vecs[i].rdy;
            cyc();
            check($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(vecs[i].ev));
            check($sformatf("vec%0d_count", i), int'(bus.fifo_count), int'(vecs[i].ec));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_len", i), int'(bus.out_len), int'(vecs[i].el));
                check($sformatf("vec%0d_sum", i), int'(bus.out_sum), int'(vecs[i].es));
                check($sformatf("vec%0d_err", i), int'(bus.out_err), int'(vecs[i].ee));
            end
        end
        drain();
        exp_q.push_back(rec(1, 1, 0));
        exp_q.push_back(rec(2, 3, 0));
        exp_q.push_back(rec(3, 6, 0));
        compare_records("table");

        // Full counter cycle of 28 samples
        for (int g = 1; g <= 7; g++) begin
            for (int k = 1; k <= g; k++) send(3'(k));
            exp_q.push_back(rec(g, g * (g + 1) / 2, 0));
        end
        flush();
        drain();
        compare_records("full_cycle");
        check("full_cycle_overflow", int'(bus.overflow), 0);

        // Sequence error
        send(3'd1); send(3'd2); send(3'd4); send(3'd5); send(3'd1);
        flush();
        drain();
        exp_q.push_back(rec(4, 12, 1));
        exp_q.push_back(rec(1, 1, 0));
        compare_records("seq_err");

        // Leading junk plus forced close at MAX_LEN; afterwards the collector must be idle
        send(3'd3); send(3'd0); send(3'd1);
        for (int i = 0; i < 7; i++) send(3'd3);
        send(3'd2);
        flush();
        drain();
        exp_q.push_back(rec(8, 22, 1));
        compare_records("forced_close");

        // Backpressure: five records into a four-entry FIFO
        bus.out_ready = 1'b0;
        send(3'd1); send(3'd1); send(3'd2); send(3'd1);
        send(3'd2); send(3'd3); send(3'd1); send(3'd1);
        flush();
        cyc();
        check("bp_count", int'(bus.fifo_count), 4);
        check("bp_overflow", int'(bus.overflow), 1);
        check("bp_valid", int'(bus.out_valid), 1);
        check("bp_nothing_popped", got.size(), 0);
        drain();
        exp_q.push_back(rec(1, 1, 0));
        exp_q.push_back(rec(2, 3, 0));
        exp_q.push_back(rec(3, 6, 0));
        exp_q.push_back(rec(1, 1, 0));
        compare_records("bp_drain");
        check("bp_overflow_sticky", int'(bus.overflow), 1);

        // Asynchronous reset with a group open and two records queued
        bus.out_ready = 1'b0;
        send(3'd1); send(3'd1); send(3'd2); send(3'd1);
        check("pre_rst_count", int'(bus.fifo_count), 2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", int'(bus.out_valid), 0);
        check("rst_async_count", int'(bus.fifo_count), 0);
        check("rst_async_overflow", int'(bus.overflow), 0);
        cyc();
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        #1;
        bus.out_ready = 1'b1;
        send(3'd1); send(3'd2);
        flush();
        drain();
        exp_q.push_back(rec(2, 3, 0));
        compare_records("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
